float_class_scheduler: RTL and testbench

//  Two-requester front end for the float->fixed path. Round-robin arbitrates

---
 rtl/float_class_scheduler.sv | 172 +++++++++++++++++
 tb/tb_float_class_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/float_class_scheduler.sv
// rtl/float_class_scheduler.sv - two-requester round-robin float classifier with one registered output slot
// Optional statistics counters enabled by defining FLOAT_CLASS_STATS_EN.
module float_class_scheduler #(
    parameter int FLOATSIZE    = 32,
    parameter int EXPONENTBITS = 8,
    parameter int MANTISSABITS = 23,
    parameter int CNTBITS      = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 InValid0,
    input  logic [FLOATSIZE-1:0] InFloat0,
    output logic                 InReady0,
    input  logic                 InValid1,
    input  logic [FLOATSIZE-1:0] InFloat1,
    output logic                 InReady1,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [FLOATSIZE-1:0] OutFloat,
    output logic                 OutSrc,
    output logic                 OutZero,
    output logic                 OutNormal,
    output logic                 OutException,
    input  logic                 StatClear,
    output logic [CNTBITS-1:0]   ExcCount,
    output logic [CNTBITS-1:0]   DenormCount
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t          slot_q, slot_d;
    logic                 last_grant_q, last_grant_d;
    logic [FLOATSIZE-1:0] word_q, word_d;
    logic                 src_q, src_d;
    logic                 zero_q, zero_d;
    logic                 normal_q, normal_d;
    logic                 exc_q, exc_d;

    logic                    grant_valid;
    logic                    grant_sel;
    logic                    accept;
    logic [FLOATSIZE-1:0]    grant_word;
    logic [EXPONENTBITS-1:0] grant_exp;
    logic [MANTISSABITS-1:0] grant_man;
    logic                    exp_zero;
    logic                    man_zero;
    logic                    cls_exc;
    logic                    cls_zero;
    logic                    cls_normal;

    // Round robin: a lone requester always wins; on contention the one that
    // did not win the last accepted transfer goes first.
    always_comb begin
        grant_valid = InValid0 | InValid1;
        if (InValid0 && InValid1) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = InValid1;
        end
        grant_word = grant_sel ? InFloat1 : InFloat0;
        accept     = grant_valid && ((slot_q == SLOT_EMPTY) || OutReady);
    end

    assign InReady0 = accept && !grant_sel;
    assign InReady1 = accept && grant_sel;

    assign grant_exp  = grant_word[FLOATSIZE-2:MANTISSABITS];
    assign grant_man  = grant_word[MANTISSABITS-1:0];
    assign exp_zero   = (grant_exp == '0);
    assign man_zero   = (grant_man == '0);
    assign cls_exc    = &grant_exp;
    assign cls_zero   = (exp_zero && man_zero) || cls_exc;
    assign cls_normal = !(exp_zero && !man_zero);

    always_comb begin
        slot_d       = slot_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        src_d        = src_q;
        zero_d       = zero_q;
        normal_d     = normal_q;
        exc_d        = exc_q;
        if (accept) begin
            slot_d       = SLOT_FULL;
            last_grant_d = grant_sel;
            word_d       = grant_word;
            src_d        = grant_sel;
            zero_d       = cls_zero;
            normal_d     = cls_normal;
            exc_d        = cls_exc;
        end else if (OutReady) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            slot_q       <= SLOT_EMPTY;
            last_grant_q <= 1'b1;
            word_q       <= '0;
            src_q        <= 1'b0;
            zero_q       <= 1'b0;
            normal_q     <= 1'b0;
            exc_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            src_q        <= src_d;
            zero_q       <= zero_d;
            normal_q     <= normal_d;
            exc_q        <= exc_d;
        end
    end

    assign OutValid     = (slot_q == SLOT_FULL);
    assign OutFloat     = word_q;
    assign OutSrc       = src_q;
    assign OutZero      = zero_q;
    assign OutNormal    = normal_q;
    assign OutException = exc_q;

`ifdef FLOAT_CLASS_STATS_EN
    localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};

    logic [CNTBITS-1:0] exc_cnt_q, exc_cnt_d;
    logic [CNTBITS-1:0] den_cnt_q, den_cnt_d;
    logic               cls_denorm;

    assign cls_denorm = exp_zero && !man_zero;

    // Clear dominates any increment landing on the same edge.
    always_comb begin
        exc_cnt_d = exc_cnt_q;
        den_cnt_d = den_cnt_q;
        if (StatClear) begin
            exc_cnt_d = '0;
            den_cnt_d = '0;
        end else if (accept) begin
            if (cls_exc && (exc_cnt_q != '1)) begin
                exc_cnt_d = exc_cnt_q + CNT_ONE;
            end
            if (cls_denorm && (den_cnt_q != '1)) begin
                den_cnt_d = den_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            exc_cnt_q <= '0;
            den_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            den_cnt_q <= den_cnt_d;
        end
    end

    assign ExcCount    = exc_cnt_q;
    assign DenormCount = den_cnt_q;
`else
    logic unused_stat_clear;

    assign unused_stat_clear = StatClear;
    assign ExcCount          = '0;
    assign DenormCount       = '0;
`endif

endmodule

// File: tb/tb_float_class_scheduler.sv
// tb/tb_float_class_scheduler.sv - self-checking bench for float_class_scheduler
module tb_float_class_scheduler;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid0, InValid1, OutReady, StatClear;
    logic [31:0] InFloat0, InFloat1;
    logic        InReady0, InReady1;
    logic        OutValid, OutSrc, OutZero, OutNormal, OutException;
    logic [31:0] OutFloat;
    logic [15:0] ExcCount, DenormCount;

    int total = 0;
    int bad   = 0;

    float_class_scheduler dut (
        .Clk(Clk), .Rst(Rst),
        .InValid0(InValid0), .InFloat0(InFloat0), .InReady0(InReady0),
        .InValid1(InValid1), .InFloat1(InFloat1), .InReady1(InReady1),
        .OutValid(OutValid), .OutReady(OutReady), .OutFloat(OutFloat),
        .OutSrc(OutSrc), .OutZero(OutZero), .OutNormal(OutNormal),
        .OutException(OutException), .StatClear(StatClear),
        .ExcCount(ExcCount), .DenormCount(DenormCount)
    );

    always #5 Clk = ~Clk;

    function automatic int unsigned f_exp(input logic [31:0] w);
        return (w / 32'h0080_0000) % 256;
    endfunction

    function automatic int unsigned f_man(input logic [31:0] w);
        return w % 32'h0080_0000;
    endfunction

    // Expected {Zero, Normal, Exception} from the IEEE field rules.
    function automatic logic [2:0] f_flags(input logic [31:0] w);
        int unsigned e, m;
        e = f_exp(w);
        m = f_man(w);
        return {((e == 0 && m == 0) || e == 255), !(e == 0 && m != 0), (e == 255)};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] s;
        s = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
        case ($urandom_range(0, 4))
            0:       return s;
            1:       return s | $urandom_range(1, 32'h007F_FFFF);
            2:       return s | 32'h7F80_0000 | ($urandom_range(0, 1) == 1 ? $urandom_range(0, 32'h007F_FFFF) : 32'h0);
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        InValid0 = 1'b0; InValid1 = 1'b0;
        InFloat0 = 32'h0; InFloat1 = 32'h0;
        OutReady = 1'b0; StatClear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst = 1'b0;
        @(negedge Clk);
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", OutValid); end
        total++; if ({InReady0, InReady1} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {InReady0, InReady1}); end
        total++; if ({OutZero, OutNormal, OutException} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {OutZero, OutNormal, OutException}); end
        total++; if ({OutFloat, OutSrc} !== 33'h0) begin bad++; $display("FAIL reset_data: got %h/%0b want 0/0", OutFloat, OutSrc); end
        total++; if ({ExcCount, DenormCount} !== 32'h0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", ExcCount, DenormCount); end
        Rst = 1'b1;
        @(negedge Clk);
        total++; if ({OutValid, InReady0, InReady1} !== 3'b000) begin bad++; $display("FAIL idle_after_reset: got %b want 000", {OutValid, InReady0, InReady1}); end
    endtask

    task automatic test_single();
        do_reset();
        InValid0 = 1'b1; InFloat0 = 32'h3F80_0000; OutReady = 1'b1;
        #1;
        total++; if ({InReady0, InReady1} !== 2'b10) begin bad++; $display("FAIL single_ready: got %b want 10", {InReady0, InReady1}); end
        @(negedge Clk);
        InValid0 = 1'b0;
        total++; if ({OutValid, OutSrc, OutFloat} !== {2'b10, 32'h3F80_0000}) begin bad++; $display("FAIL single_out: got %0b/%0b/%h want 1/0/3f800000", OutValid, OutSrc, OutFloat); end
        total++; if ({OutZero, OutNormal, OutException} !== 3'b010) begin bad++; $display("FAIL single_flags: got %b want 010", {OutZero, OutNormal, OutException}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        InValid0 = 1'b1; InFloat0 = 32'h4000_0000;
        InValid1 = 1'b1; InFloat1 = 32'hC040_0000;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            total++;
            if ({OutValid, OutSrc} !== {1'b1, 1'(i % 2)}) begin
                bad++; $display("FAIL alternate_%0d: got valid=%0b src=%0b want valid=1 src=%0d", i, OutValid, OutSrc, i % 2);
            end
        end
        InValid0 = 1'b0; InValid1 = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        InValid1 = 1'b1; InFloat1 = 32'h7F80_0000; OutReady = 1'b0;
        @(negedge Clk);
        InFloat1 = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({OutValid, OutFloat, OutZero, OutException, InReady1} !== {1'b1, 32'h7F80_0000, 2'b11, 1'b0}) begin
                bad++; $display("FAIL hold_%0d: got v=%0b f=%h z=%0b e=%0b r1=%0b want 1/7f800000/1/1/0", i, OutValid, OutFloat, OutZero, OutException, InReady1);
            end
            @(negedge Clk);
        end
        OutReady = 1'b1;
        #1;
        total++; if (InReady1 !== 1'b1) begin bad++; $display("FAIL release_ready: got %0b want 1", InReady1); end
        @(negedge Clk);
        InValid1 = 1'b0;
        total++; if ({OutValid, OutSrc, OutFloat} !== {2'b11, 32'h0000_0001}) begin bad++; $display("FAIL denorm_out: got %0b/%0b/%h want 1/1/00000001", OutValid, OutSrc, OutFloat); end
        total++; if ({OutZero, OutNormal, OutException} !== 3'b000) begin bad++; $display("FAIL denorm_flags: got %b want 000", {OutZero, OutNormal, OutException}); end
        @(negedge Clk);
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL drain_valid: got %0b want 0", OutValid); end
    endtask

    task automatic test_neg_zero_reset();
        do_reset();
        InValid0 = 1'b1; InFloat0 = 32'h8000_0000; OutReady = 1'b1;
        @(negedge Clk);
        InValid0 = 1'b0; OutReady = 1'b0;
        total++; if ({OutValid, OutZero, OutNormal, OutException} !== 4'b1110) begin bad++; $display("FAIL negzero: got %b want 1110", {OutValid, OutZero, OutNormal, OutException}); end
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        total++; if ({OutValid, OutFloat} !== 33'h0) begin bad++; $display("FAIL async_reset: got %0b/%h want 0/0", OutValid, OutFloat); end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_stats();
        logic [31:0] seq [5];
        seq = '{32'h7F80_0000, 32'h0000_0001, 32'hFFC0_0000, 32'h0040_0000, 32'h7F80_0001};
        do_reset();
        OutReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            InValid0 = 1'b1; InFloat0 = seq[i];
            @(negedge Clk);
        end
        InValid0 = 1'b0;
        @(negedge Clk);
`ifdef FLOAT_CLASS_STATS_EN
        total++; if ({ExcCount, DenormCount} !== {16'd3, 16'd2}) begin bad++; $display("FAIL stats_counts: got %0d/%0d want 3/2", ExcCount, DenormCount); end
        InValid0 = 1'b1; InFloat0 = 32'h7F80_0000; StatClear = 1'b1;
        @(negedge Clk);
        InValid0 = 1'b0; StatClear = 1'b0;
        total++; if ({ExcCount, DenormCount} !== 32'h0) begin bad++; $display("FAIL stats_clear: got %0d/%0d want 0/0", ExcCount, DenormCount); end
`else
        total++; if ({ExcCount, DenormCount} !== 32'h0) begin bad++; $display("FAIL stats_tied: got %0d/%0d want 0/0", ExcCount, DenormCount); end
`endif
    endtask

    // Reference: a one-entry slot, fairness by "whoever did not win last", counters as plain tallies.
    task automatic test_random();
        logic        m_full, m_src, m_last, sel, acc;
        logic [31:0] m_word, w;
        int          m_exc, m_den;
        do_reset();
        m_full = 1'b0; m_src = 1'b0; m_last = 1'b1; m_word = 32'h0;
        m_exc = 0; m_den = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            InValid0  = ($urandom_range(0, 3) != 0);
            InValid1  = ($urandom_range(0, 3) != 0);
            InFloat0  = rand_word();
            InFloat1  = rand_word();
            OutReady  = ($urandom_range(0, 2) != 0);
            StatClear = ($urandom_range(0, 15) == 0);
            if (InValid0 && InValid1) sel = !m_last;
            else                      sel = InValid1;
            w   = sel ? InFloat1 : InFloat0;
            acc = (InValid0 || InValid1) && (!m_full || OutReady);
            #1;
            total++;
            if ({InReady0, InReady1} !== {acc && !sel, acc && sel}) begin
                bad++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, {InReady0, InReady1}, {acc && !sel, acc && sel});
            end
            @(posedge Clk);
            if (acc) begin
                m_full = 1'b1; m_word = w; m_src = sel; m_last = sel;
            end else if (OutReady) begin
                m_full = 1'b0;
            end
            if (StatClear) begin
                m_exc = 0; m_den = 0;
            end else if (acc) begin
                if (f_exp(w) == 255 && m_exc < 65535) m_exc++;
                if (f_exp(w) == 0 && f_man(w) != 0 && m_den < 65535) m_den++;
            end
            @(negedge Clk);
            total++;
            if (OutValid !== m_full) begin bad++; $display("FAIL rand_valid cyc%0d: got %0b want %0b", cyc, OutValid, m_full); end
            if (m_full) begin
                total++;
                if ({OutFloat, OutSrc, OutZero, OutNormal, OutException} !== {m_word, m_src, f_flags(m_word)}) begin
                    bad++; $display("FAIL rand_slot cyc%0d: got %h/%0b/%b want %h/%0b/%b", cyc, OutFloat, OutSrc,
                                    {OutZero, OutNormal, OutException}, m_word, m_src, f_flags(m_word));
                end
            end
`ifdef FLOAT_CLASS_STATS_EN
            total++;
            if ({ExcCount, DenormCount} !== {16'(m_exc), 16'(m_den)}) begin
                bad++; $display("FAIL rand_counts cyc%0d: got %0d/%0d want %0d/%0d", cyc, ExcCount, DenormCount, m_exc, m_den);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        Rst = 1'b0;
        @(negedge Clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_neg_zero_reset();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
